// File: rtl/ram_bist_pkg.sv
// Shared types and the March C- element table for the RAM BIST sequencer.
package ram_bist_pkg;

    typedef enum logic [3:0] {
        IDLE, M0, M1, M2, M3, M4, M5, TAIL, DONE
    } bist_state_e;

    typedef struct packed {
        logic down;
        logic has_read;
        logic exp_inv;
        logic has_write;
        logic wr_inv;
    } march_elem_t;

    // Element order matches M0..M5.
    localparam march_elem_t MARCH_C_MINUS [6] = '{
        '{down: 1'b0, has_read: 1'b0, exp_inv: 1'b0, has_write: 1'b1, wr_inv: 1'b0},
        '{down: 1'b0, has_read: 1'b1, exp_inv: 1'b0, has_write: 1'b1, wr_inv: 1'b1},
        '{down: 1'b0, has_read: 1'b1, exp_inv: 1'b1, has_write: 1'b1, wr_inv: 1'b0},
        '{down: 1'b1, has_read: 1'b1, exp_inv: 1'b0, has_write: 1'b1, wr_inv: 1'b1},
        '{down: 1'b1, has_read: 1'b1, exp_inv: 1'b1, has_write: 1'b1, wr_inv: 1'b0},
        '{down: 1'b0, has_read: 1'b1, exp_inv: 1'b0, has_write: 1'b0, wr_inv: 1'b0}
    };

    localparam logic [15:0] BG_PATTERN_DEF = 16'h5A5A;

    function automatic logic is_march(bist_state_e s);
        return s inside {M0, M1, M2, M3, M4, M5};
    endfunction

    function automatic logic [2:0] elem_idx(bist_state_e s);
        case (s)
            M1:      return 3'd1;
            M2:      return 3'd2;
            M3:      return 3'd3;
            M4:      return 3'd4;
            M5:      return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic bist_state_e next_elem(bist_state_e s);
        case (s)
            M0:      return M1;
            M1:      return M2;
            M2:      return M3;
            M3:      return M4;
            M4:      return M5;
            M5:      return TAIL;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Loadable up/down address counter; last flags the terminal address of the sweep.
module ram_bist_addr_gen #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              load_down,
    input  logic              step,
    input  logic              down,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr <= '0;
        else if (load)
            addr <= load_down ? '1 : '0;
        else if (step)
            addr <= down ? addr - 1'b1 : addr + 1'b1;
    end

    assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/ram_bist_ctrl.sv
// March C- BIST sequencer for a single-port RAM with registered read data.
// Build option: RAM_BIST_STOP_ON_FAIL_EN ends the test at the first mismatch.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] BG_PATTERN = BG_PATTERN_DEF,
    parameter int                CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [CNT_W-1:0]  fail_count
);

    bist_state_e       state, state_nxt;
    logic              phase, phase_nxt;
    logic [2:0]        ce;
    logic              ag_load, ag_load_down, ag_step, ag_last;
    logic              cmp_vld, mism, kick;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_exp, data_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    ram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .down      (MARCH_C_MINUS[ce].down),
        .addr      (ram_addr),
        .last      (ag_last)
    );

    always_comb begin
        ce        = elem_idx(state);
        busy      = (state != IDLE) && (state != DONE);
        done      = (state == DONE);
        kick      = (state == IDLE) && start;
        // Two-op elements read on phase 0 and write on phase 1; single-op ones use phase 0 only.
        ram_read  = is_march(state) && MARCH_C_MINUS[ce].has_read && !phase;
        ram_write = is_march(state) && MARCH_C_MINUS[ce].has_write
                    && (phase || !MARCH_C_MINUS[ce].has_read);
        mism      = cmp_vld && busy && (ram_out != rd_exp);
        if (kick)
            cnt_nxt = '0;
        else if (mism && (fail_count != '1))
            cnt_nxt = fail_count + 1'b1;
        else
            cnt_nxt = fail_count;
    end

    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = M0;
                ag_load   = 1'b1;
            end
            M0, M1, M2, M3, M4, M5: begin
                if (MARCH_C_MINUS[ce].has_read && MARCH_C_MINUS[ce].has_write && !phase) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    if (ag_last) begin
                        state_nxt    = next_elem(state);
                        ag_load      = 1'b1;
                        ag_load_down = MARCH_C_MINUS[elem_idx(next_elem(state))].down;
                    end else begin
                        ag_step = 1'b1;
                    end
                end
            end
            TAIL:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`ifdef RAM_BIST_STOP_ON_FAIL_EN
        if (mism) begin
            state_nxt = DONE;
            phase_nxt = 1'b0;
            ag_load   = 1'b0;
            ag_step   = 1'b0;
        end
`endif
    end

    always_comb begin
        data_nxt = '0;
        if (is_march(state_nxt))
            data_nxt = MARCH_C_MINUS[elem_idx(state_nxt)].wr_inv ? ~BG_PATTERN : BG_PATTERN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= 1'b0;
            cmp_vld    <= 1'b0;
            rd_addr    <= '0;
            rd_exp     <= '0;
            ram_data   <= '0;
            fail_count <= '0;
            fail_addr  <= '0;
            pass       <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            // Read data returns one cycle later; carry its address and expected word alongside.
            cmp_vld    <= ram_read;
            rd_addr    <= ram_addr;
            rd_exp     <= MARCH_C_MINUS[ce].exp_inv ? ~BG_PATTERN : BG_PATTERN;
            ram_data   <= data_nxt;
            fail_count <= cnt_nxt;
            if (kick)
                fail_addr <= '0;
            else if (mism && (fail_count == '0))
                fail_addr <= rd_addr;
            if (kick)
                pass <= 1'b0;
            else if ((state_nxt == DONE) && (state != DONE))
                pass <= (cnt_nxt == '0);
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a behavioural 256x16 RAM and injectable faults.
module tb_ram_bist_ctrl;

    localparam int AW = 8, DW = 16, CW = 8, N = 256;
    localparam int FULL_DONE = 10 * N + 2;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
    localparam int EXP_STUCK = 1, EXP_COUP = 1, EXP_SAT = 1;
`else
    // Stuck bit0=1 at 3C breaks every r(W): M1, M3 and M5.
    localparam int EXP_STUCK = 3, EXP_COUP = 2, EXP_SAT = 255;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic          ram_read, ram_write, busy, done, pass;
    logic [AW-1:0] ram_addr, fail_addr;
    logic [DW-1:0] ram_data, ram_out;
    logic [CW-1:0] fail_count;

    int checks = 0, failures = 0;
    int fault = 0, both_cnt = 0;
    int r_first, r_nbusy, r_done, r_ndone;
    logic r_pass_done, r_pass_after, r_pass_c1;
    logic [CW-1:0] r_cnt_c1;
    logic [DW-1:0] mem [N];

    always #5 clk = ~clk;

    ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BG_PATTERN(16'h5A5A), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ram_read   (ram_read),
        .ram_write  (ram_write),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_out    (ram_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .fail_count (fail_count)
    );

    // fault 1: bit0 stuck-at-1 at 3C; 2: write to 10 also lands in 11; 3: read data stuck at 0
    always @(posedge clk) begin
        logic [DW-1:0] rd;
        if (ram_read && ram_write) both_cnt <= both_cnt + 1;
        if (ram_write) begin
            mem[ram_addr] <= ram_data;
            if (fault == 2 && ram_addr == 8'h10) mem[8'h11] <= ram_data;
        end
        if (ram_read) begin
            rd = mem[ram_addr];
            if (fault == 1 && ram_addr == 8'h3C) rd[0] = 1'b1;
            if (fault == 3) rd = '0;
            ram_out <= rd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rd"},   32'(ram_read), 0);
        chk({tag, "_wr"},   32'(ram_write), 0);
        chk({tag, "_addr"}, 32'(ram_addr), 0);
        chk({tag, "_data"}, 32'(ram_data), 0);
        chk({tag, "_cnt"},  32'(fail_count), 0);
        chk({tag, "_faddr"}, 32'(fail_addr), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
    endtask

    // Start is sampled at the edge ending cycle 0; sampling happens 1 time unit after each edge.
    task automatic run(input int f, input bit poke);
        fault = f;
        r_first = -1; r_nbusy = 0; r_done = -1; r_ndone = 0;
        r_pass_done = 1'bx; r_pass_after = 1'bx; r_pass_c1 = 1'bx; r_cnt_c1 = 'x;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 3000; n++) begin
            if (n == 1) begin r_pass_c1 = pass; r_cnt_c1 = fail_count; end
            if (busy) begin
                r_nbusy++;
                if (r_first < 0) r_first = n;
            end
            if (done) begin
                r_ndone++;
                if (r_done < 0) begin r_done = n; r_pass_done = pass; end
            end
            start = poke && (n == 5 || n == 1000);
            if (r_done >= 0 && n == r_done + 1) begin
                r_pass_after = pass;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (r_done < 0) chk("timeout_no_done", 0, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_idle_outs("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run(0, 1'b1);
        chk("clean_first_busy", 32'(r_first), 1);
        chk("clean_busy_len", 32'(r_nbusy), 32'(10 * N + 1));
        chk("clean_done_cyc", 32'(r_done), 32'(FULL_DONE));
        chk("clean_done_width", 32'(r_ndone), 1);
        chk("clean_pass", 32'(r_pass_done), 1);
        chk("clean_pass_held", 32'(r_pass_after), 1);
        chk("clean_cnt", 32'(fail_count), 0);

        run(1, 1'b0);
        chk("stuck_pass_clr_on_start", 32'(r_pass_c1), 0);
        chk("stuck_pass", 32'(r_pass_done), 0);
        chk("stuck_faddr", 32'(fail_addr), 32'h3C);
        chk("stuck_cnt", 32'(fail_count), 32'(EXP_STUCK));
`ifndef RAM_BIST_STOP_ON_FAIL_EN
        chk("stuck_done_cyc", 32'(r_done), 32'(FULL_DONE));
`endif

        run(2, 1'b0);
        chk("coup_cnt_clr_on_start", 32'(r_cnt_c1), 0);
        chk("coup_pass", 32'(r_pass_done), 0);
        chk("coup_faddr", 32'(fail_addr), 32'h11);
        chk("coup_cnt", 32'(fail_count), 32'(EXP_COUP));

        run(3, 1'b0);
        chk("sat_pass", 32'(r_pass_done), 0);
        chk("sat_faddr", 32'(fail_addr), 0);
        chk("sat_cnt", 32'(fail_count), 32'(EXP_SAT));

        // Abort a fault-free run at cycle 700 with an asynchronous reset.
        fault = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (699) @(posedge clk);
        #1 chk("abort_busy_before", 32'(busy), 1);
        #1 rst_n = 1'b0;
        #1 chk_idle_outs("abort");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run(0, 1'b0);
        chk("rerun_done_cyc", 32'(r_done), 32'(FULL_DONE));
        chk("rerun_pass", 32'(r_pass_done), 1);
        chk("rerun_cnt", 32'(fail_count), 0);

        chk("rd_wr_never_both", 32'(both_cnt), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
